// File: rtl/pgm_ddram_pkg.sv
// Shared types and helpers for the PGM DDRAM port arbiter and its optional cpu read cache.
package pgm_ddram_pkg;

  localparam int DDR_AW = 29;
  localparam int TAG_W  = 24;

  typedef enum logic [2:0] {QUIET, IDLE, WR, RD, RD_WAIT} ddr_state_t;
  typedef enum logic [1:0] {DL, VID, CPU} req_id_t;

  // One 16-bit lane inside the 64-bit DDRAM word
  function automatic logic [7:0] byte_en(input logic [1:0] word_sel);
    return 8'b0000_0011 << {word_sel, 1'b0};
  endfunction

  // Wraps modulo 2^29; no saturation
  function automatic logic [DDR_AW-1:0] ddr_word_addr(input logic [DDR_AW-1:0] base,
                                                      input logic [TAG_W-1:0]  word);
    return base + {5'd0, word};
  endfunction

endpackage

// File: rtl/pgm_ddram_rdcache.sv
// One-line 64-bit read cache for the 68k port: tag/valid/data, invalidated by overlapping download writes.
module pgm_ddram_rdcache
  import pgm_ddram_pkg::*;
(
  input  logic             fixed_50m_clk,
  input  logic             reset,
  input  logic             inv_all,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_data,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [63:0]      rd_data
);

  logic             valid_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [63:0]      data_reg;

  always_ff @(posedge fixed_50m_clk) begin
    if (reset || inv_all) begin
      valid_reg <= 1'b0;
    end else if (wr_en && valid_reg && (wr_tag == tag_reg)) begin
      valid_reg <= 1'b0;
    end else if (fill_en) begin
      valid_reg <= 1'b1;
    end
    // Tag/data need no reset: they are only consulted while valid_reg is set
    if (fill_en) begin
      tag_reg  <= fill_tag;
      data_reg <= fill_data;
    end
  end

  assign hit     = valid_reg && (rd_tag == tag_reg);
  assign rd_data = data_reg;

endmodule

// File: rtl/pgm_ddram_arbiter.sv
// Shares the PGM 64-bit DDRAM port between HPS download writes, video fetch and 68k fetch.
// Define PGM_DDR_RDCACHE_EN to add a one-line read cache in front of the 68k port.
module pgm_ddram_arbiter
  import pgm_ddram_pkg::*;
#(
  parameter logic [DDR_AW-1:0] BASE_ADDR    = 29'h0000000,
  parameter int                QUIET_CYCLES = 64
) (
  input  logic              fixed_50m_clk,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_req,
  input  logic [26:0]       dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_ack,
  output logic              ioctl_wait,
  input  logic              vid_req,
  input  logic [26:0]       vid_addr,
  output logic [63:0]       vid_dout,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic [26:0]       cpu_addr,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  output logic [DDR_AW-1:0] ddram_addr,
  output logic              ddram_rd,
  output logic              ddram_we,
  output logic [63:0]       ddram_din,
  output logic [7:0]        ddram_be,
  input  logic              ddram_busy,
  input  logic [63:0]       ddram_dout,
  input  logic              ddram_dout_ready
);

  localparam logic [15:0] QUIET_INIT = 16'(QUIET_CYCLES);

  ddr_state_t        state_reg, state_next;
  req_id_t           grant_reg, grant_next;
  req_id_t           rr_reg, rr_next;
  logic [15:0]       quiet_cnt_reg, quiet_cnt_next;
  logic [DDR_AW-1:0] addr_reg, addr_next;
  logic [63:0]       din_reg, din_next;
  logic [7:0]        be_reg, be_next;
  logic [1:0]        word_sel_reg, word_sel_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic              dl_ack_reg, dl_ack_next;
  logic              vid_ack_reg, vid_ack_next;
  logic              cpu_ack_reg, cpu_ack_next;
  logic [63:0]       vid_dout_reg, vid_dout_next;
  logic [15:0]       cpu_dout_reg, cpu_dout_next;
  logic              dl_active_reg;

  logic              any_ack;
  logic              pick_cpu;
  logic              cache_hit;
  logic              cache_inv;
  logic              cache_wr;
  logic              cache_fill;
  logic [63:0]       cache_data;
  logic [15:0]       rd_words   [4];
  logic [15:0]       line_words [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_words
      assign rd_words[gi]   = ddram_dout[16*gi +: 16];
      assign line_words[gi] = cache_data[16*gi +: 16];
    end
  endgenerate

  // During an ack pulse the requester still shows its old request, so no grant is made
  assign any_ack   = dl_ack_reg | vid_ack_reg | cpu_ack_reg;
  assign pick_cpu  = cpu_req && (!vid_req || (rr_reg == CPU));
  assign cache_inv = dl_active && !dl_active_reg;

`ifdef PGM_DDR_RDCACHE_EN
  pgm_ddram_rdcache u_rdcache (
    .fixed_50m_clk (fixed_50m_clk),
    .reset         (reset),
    .inv_all       (cache_inv),
    .wr_en         (cache_wr),
    .wr_tag        (dl_addr[26:3]),
    .fill_en       (cache_fill),
    .fill_tag      (tag_reg),
    .fill_data     (ddram_dout),
    .rd_tag        (cpu_addr[26:3]),
    .hit           (cache_hit),
    .rd_data       (cache_data)
  );
`else
  logic unused_cache;
  assign cache_hit    = 1'b0;
  assign cache_data   = '0;
  assign unused_cache = ^{cache_inv, cache_wr, cache_fill, tag_reg};
`endif

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_next        = rr_reg;
    quiet_cnt_next = quiet_cnt_reg;
    addr_next      = addr_reg;
    din_next       = din_reg;
    be_next        = be_reg;
    word_sel_next  = word_sel_reg;
    tag_next       = tag_reg;
    vid_dout_next  = vid_dout_reg;
    cpu_dout_next  = cpu_dout_reg;
    dl_ack_next    = 1'b0;
    vid_ack_next   = 1'b0;
    cpu_ack_next   = 1'b0;
    cache_wr       = 1'b0;
    cache_fill     = 1'b0;

    case (state_reg)
      QUIET: begin
        if (quiet_cnt_reg == 16'd0) state_next = IDLE;
        else                        quiet_cnt_next = quiet_cnt_reg - 16'd1;
      end

      IDLE: begin
        if (!any_ack) begin
          if (dl_req) begin
            grant_next = DL;
            addr_next  = ddr_word_addr(BASE_ADDR, dl_addr[26:3]);
            din_next   = {4{dl_data}};
            be_next    = byte_en(dl_addr[2:1]);
            tag_next   = dl_addr[26:3];
            cache_wr   = 1'b1;
            state_next = WR;
          end else if (!dl_active && pick_cpu && cache_hit) begin
            // Cache hit: answered from the line, round-robin untouched
            cpu_dout_next = line_words[cpu_addr[2:1]];
            cpu_ack_next  = 1'b1;
          end else if (!dl_active && pick_cpu) begin
            grant_next    = CPU;
            rr_next       = VID;
            addr_next     = ddr_word_addr(BASE_ADDR, cpu_addr[26:3]);
            word_sel_next = cpu_addr[2:1];
            tag_next      = cpu_addr[26:3];
            state_next    = RD;
          end else if (!dl_active && vid_req) begin
            grant_next = VID;
            rr_next    = CPU;
            addr_next  = ddr_word_addr(BASE_ADDR, vid_addr[26:3]);
            tag_next   = vid_addr[26:3];
            state_next = RD;
          end
        end
      end

      WR: begin
        if (!ddram_busy) begin
          dl_ack_next = 1'b1;
          state_next  = IDLE;
        end
      end

      RD: begin
        if (!ddram_busy) state_next = RD_WAIT;
      end

      RD_WAIT: begin
        if (ddram_dout_ready) begin
          state_next = IDLE;
          if (grant_reg == CPU) begin
            cpu_dout_next = rd_words[word_sel_reg];
            cpu_ack_next  = 1'b1;
            cache_fill    = 1'b1;
          end else begin
            vid_dout_next = ddram_dout;
            vid_ack_next  = 1'b1;
          end
        end
      end

      default: state_next = QUIET;
    endcase
  end

  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      state_reg     <= QUIET;
      grant_reg     <= DL;
      rr_reg        <= VID;
      quiet_cnt_reg <= QUIET_INIT;
      addr_reg      <= '0;
      din_reg       <= '0;
      be_reg        <= '0;
      word_sel_reg  <= '0;
      tag_reg       <= '0;
      dl_ack_reg    <= 1'b0;
      vid_ack_reg   <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      vid_dout_reg  <= '0;
      cpu_dout_reg  <= '0;
      dl_active_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_reg        <= rr_next;
      quiet_cnt_reg <= quiet_cnt_next;
      addr_reg      <= addr_next;
      din_reg       <= din_next;
      be_reg        <= be_next;
      word_sel_reg  <= word_sel_next;
      tag_reg       <= tag_next;
      dl_ack_reg    <= dl_ack_next;
      vid_ack_reg   <= vid_ack_next;
      cpu_ack_reg   <= cpu_ack_next;
      vid_dout_reg  <= vid_dout_next;
      cpu_dout_reg  <= cpu_dout_next;
      dl_active_reg <= dl_active;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{dl_addr[0], vid_addr[2:0], cpu_addr[0]};

  assign ddram_addr = addr_reg;
  assign ddram_din  = din_reg;
  assign ddram_be   = be_reg;
  assign ddram_we   = (state_reg == WR);
  assign ddram_rd   = (state_reg == RD);
  assign dl_ack     = dl_ack_reg;
  assign vid_ack    = vid_ack_reg;
  assign cpu_ack    = cpu_ack_reg;
  assign vid_dout   = vid_dout_reg;
  assign cpu_dout   = cpu_dout_reg;
  assign ioctl_wait = dl_req & ~dl_ack_reg;

endmodule

// File: doc/pgm_ddram_arbiter.md
Name: pgm_ddram_arbiter

Overview:
Shares the single 64-bit DDRAM port of the PGM core between three requesters: the HPS ROM-download writer, the video/sprite fetcher and the 68k ROM fetch path. Sequences DDRAM read/write transactions (burst length 1, one outstanding at a time) and drives the download pause (ioctl_wait). Sits inside PGM between the requesters and the ddram_* pins.

Parameters:
BASE_ADDR, 29'h0000000, DDRAM 64-bit word offset added to every requester address
QUIET_CYCLES, 64, cycles after reset during which no DDRAM command is issued (drains stale read returns)

Ports:
fixed_50m_clk  in  1  sole clock; DDRAM_CLK domain
reset  in  1  synchronous, active-high
dl_active  in  1  download in progress (ioctl_download); blocks cpu/vid grants
dl_req  in  1  download word write request (level)
dl_addr  in  27  byte address, bit 0 ignored
dl_data  in  16  write word
dl_ack  out  1  one-cycle pulse: write accepted by DDRAM
ioctl_wait  out  1  high when dl_req is pending and not yet acked
vid_req  in  1  video read request (level)
vid_addr  in  27  byte address, bits 2:0 ignored
vid_dout  out  64  read data, valid with vid_ack
vid_ack  out  1  one-cycle pulse
cpu_req  in  1  68k read request (level)
cpu_addr  in  27  byte address, bit 0 ignored
cpu_dout  out  16  selected word, valid with cpu_ack
cpu_ack  out  1  one-cycle pulse
ddram_addr  out  29  BASE_ADDR + addr[26:3]
ddram_rd  out  1
ddram_we  out  1
ddram_din  out  64  {4{dl_data}}
ddram_be  out  8  2'b11 << (2*dl_addr[2:1])
ddram_busy  in  1
ddram_dout  in  64
ddram_dout_ready  in  1

Behaviour:
- Reset: all outputs 0 (ioctl_wait 0, be 0, addr 0), state QUIET, quiet counter loaded with QUIET_CYCLES, round-robin pointer = vid; reset in any state aborts immediately.
- States: QUIET -> IDLE when counter reaches 0; ddram_dout_ready ignored in QUIET and IDLE.
- IDLE grant, evaluated every cycle: dl_req first (absolute priority); else if !dl_active, vid_req vs cpu_req by round-robin (pointer flips to the other after each read grant; a sole requester wins regardless). Grant latches address/data; IDLE->WR or RD next cycle.
- WR: ddram_we=1 with addr/din/be stable until cycle with ddram_busy=0 (command accepted); dl_ack pulses the following cycle; -> IDLE. Minimum 3 cycles req-to-ack with busy=0.
- RD: ddram_rd=1 held until busy=0; -> RD_WAIT with rd low. RD_WAIT: on ddram_dout_ready latch ddram_dout; next cycle pulse the granted requester's ack with data; -> IDLE. Data outputs hold until next ack.
- cpu_dout = latched[16*cpu_addr[2:1] +: 16] (word 0 = bits 15:0).
- Level handshake: req held with stable addr until ack; req still high in the cycle after ack is a new request (requester updates addr on ack).
- ioctl_wait = dl_req & ~(dl_ack); asserted combinationally from the request cycle.
- ddram_addr arithmetic: 29-bit wrap-around, no saturation.
- dl_req arriving during a read: waits for read completion (no preemption).

Optional Feature:
PGM_DDR_RDCACHE_EN: one-line 64-bit cache for the cpu port (tag = cpu_addr[26:3], valid bit). With it: cpu request hitting a valid line acks 1 cycle after request, no DDRAM access, round-robin pointer unchanged; every cpu miss fills the line; any dl write to the tagged line, dl_active rising, or reset clears valid. Without it: every cpu request goes to DDRAM.

Decomposition:
Package pgm_ddram_pkg: state enum (QUIET, IDLE, WR, RD, RD_WAIT), requester-id enum (DL, VID, CPU), DDR word-address width constant (29), byte-enable helper. Optional sub-module pgm_ddram_rdcache (tag/valid/data line), instantiated only under PGM_DDR_RDCACHE_EN.

Test Plan:
Reset, cpu_req high immediately -> ddram_rd stays 0 for 64 cycles, then issued; stale ddram_dout_ready in quiet cycle produces no ack.
dl_req addr 27'h000006 data 16'hBEEF, busy high 5 cycles -> we held 5+1 cycles, ddram_addr=BASE+0, be=8'hC0, din=64'hBEEF_BEEF_BEEF_BEEF, one dl_ack, ioctl_wait high until ack.
cpu_req addr 27'h000104, dout 64'h4444_3333_2222_1111 -> ddram_addr=0x20, cpu_dout=16'h3333 on single cpu_ack.
vid_req and cpu_req held continuously -> grants alternate vid,cpu,vid,cpu; no ack starvation.
dl_active=1 with dl_req, vid_req, cpu_req high -> only dl writes issued until dl_active falls.
Cache on: cpu reads 0x100 twice -> second acks in 1 cycle, no ddram_rd; dl write to 0x102 then read -> DDRAM re-read.
